// File: rtl/pipeline_pkg.sv
// Shared RV32I pipeline types: register index, address, boolean/clock aliases
// and the hazard controller's state encoding.
package pipeline_pkg;

    typedef logic        Clock;
    typedef logic        Bool;
    typedef logic [31:0] Addr;
    typedef logic [4:0]  RegIdx;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MULDIV   = 2'd2,
        FLUSH    = 2'd3
    } HazardState;

    localparam RegIdx REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Pure load-use comparator: a load in execute whose destination is read by the
// instruction in decode. x0 never creates a dependency.
module load_use_detect
    import pipeline_pkg::*;
(
    input  RegIdx id_rs1_i,
    input  RegIdx id_rs2_i,
    input  Bool   id_uses_rs1_i,
    input  Bool   id_uses_rs2_i,
    input  Bool   ex_is_load_i,
    input  RegIdx ex_rd_i,
    output Bool   hazard_o
);

    Bool rs1_hit;
    Bool rs2_hit;

    assign rs1_hit  = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit  = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
    assign hazard_o = ex_is_load_i && (ex_rd_i != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_controller.sv
// Prioritised stall/flush/redirect sequencer for the 5-stage pipeline.
// Optional HAZARD_PERF_COUNTERS_EN adds stall/flush cycle counters.
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int unsigned MULDIV_LATENCY = 4,
    parameter int unsigned FLUSH_CYCLES   = 2
) (
    input  Clock        clk,
    input  logic        reset,
    input  RegIdx       id_rs1,
    input  RegIdx       id_rs2,
    input  Bool         id_uses_rs1,
    input  Bool         id_uses_rs2,
    input  Bool         ex_is_load,
    input  RegIdx       ex_rd,
    input  Bool         ex_muldiv_start,
    input  Bool         ex_branch_taken,
    input  Addr         ex_branch_target,
    input  Bool         mem_busy,
    output logic        fetch_stall,
    output logic        jump_enable,
    output Addr         jump_address,
    output logic        decode_stall,
    output logic        decode_flush,
    output logic        execute_stall,
    output logic        execute_bubble,
    output logic        memory_bubble,
`ifdef HAZARD_PERF_COUNTERS_EN
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_cycles,
`endif
    output HazardState  dbg_state
);

    localparam logic [3:0] MUL_LOAD   = 4'(MULDIV_LATENCY - 1);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    HazardState state_q, state_d;
    HazardState saved_q, saved_d;
    HazardState eff_state;
    logic [3:0] mul_cnt_q, mul_cnt_d;
    logic [3:0] flush_cnt_q, flush_cnt_d;
    logic       pend_q, pend_d;
    Addr        pend_tgt_q, pend_tgt_d;
    Bool        load_use;
    logic       redirect;
    Addr        redirect_tgt;

    load_use_detect u_load_use (
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .ex_is_load_i  (ex_is_load),
        .ex_rd_i       (ex_rd),
        .hazard_o      (load_use)
    );

    // The cycle mem_busy drops behaves as the interrupted state would have.
    assign eff_state    = (state_q == MEM_WAIT) ? saved_q : state_q;
    assign redirect     = pend_q || ex_branch_taken;
    assign redirect_tgt = pend_q ? pend_tgt_q : ex_branch_target;
    assign dbg_state    = state_q;

    always_comb begin
        state_d        = state_q;
        saved_d        = saved_q;
        mul_cnt_d      = mul_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        pend_d         = pend_q;
        pend_tgt_d     = pend_tgt_q;
        fetch_stall    = 1'b0;
        jump_enable    = 1'b0;
        jump_address   = '0;
        decode_stall   = 1'b0;
        decode_flush   = 1'b0;
        execute_stall  = 1'b0;
        execute_bubble = 1'b0;
        memory_bubble  = 1'b0;

        if (mem_busy) begin
            fetch_stall   = 1'b1;
            decode_stall  = 1'b1;
            execute_stall = 1'b1;
            state_d       = MEM_WAIT;
            if (state_q != MEM_WAIT) saved_d = state_q;
            if (ex_branch_taken) begin
                pend_d     = 1'b1;
                pend_tgt_d = ex_branch_target;
            end
        end else if (redirect) begin
            jump_enable    = 1'b1;
            jump_address   = redirect_tgt;
            decode_flush   = 1'b1;
            execute_bubble = 1'b1;
            pend_d         = 1'b0;
            mul_cnt_d      = '0;
            flush_cnt_d    = FLUSH_LOAD;
            state_d        = (FLUSH_LOAD != 4'd0) ? FLUSH : RUN;
        end else begin
            case (eff_state)
                FLUSH: begin
                    decode_flush = 1'b1;
                    flush_cnt_d  = (flush_cnt_q != 4'd0) ? flush_cnt_q - 4'd1 : 4'd0;
                    state_d      = (flush_cnt_q <= 4'd1) ? RUN : FLUSH;
                end
                MULDIV: begin
                    // Counter holds busy cycles left including this one; the last one releases.
                    if (mul_cnt_q > 4'd1) begin
                        fetch_stall   = 1'b1;
                        decode_stall  = 1'b1;
                        execute_stall = 1'b1;
                        memory_bubble = 1'b1;
                    end
                    mul_cnt_d = (mul_cnt_q != 4'd0) ? mul_cnt_q - 4'd1 : 4'd0;
                    state_d   = (mul_cnt_q <= 4'd1) ? RUN : MULDIV;
                end
                default: begin
                    state_d = RUN;
                    if (ex_muldiv_start) begin
                        fetch_stall   = 1'b1;
                        decode_stall  = 1'b1;
                        execute_stall = 1'b1;
                        memory_bubble = 1'b1;
                        mul_cnt_d     = MUL_LOAD;
                        state_d       = MULDIV;
                    end else if (load_use) begin
                        fetch_stall    = 1'b1;
                        decode_stall   = 1'b1;
                        execute_bubble = 1'b1;
                    end
                end
            endcase
        end

        if (reset) begin
            fetch_stall    = 1'b0;
            jump_enable    = 1'b0;
            jump_address   = '0;
            decode_stall   = 1'b0;
            decode_flush   = 1'b0;
            execute_stall  = 1'b0;
            execute_bubble = 1'b0;
            memory_bubble  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            saved_q     <= RUN;
            mul_cnt_q   <= '0;
            flush_cnt_q <= '0;
            pend_q      <= 1'b0;
            pend_tgt_q  <= '0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            mul_cnt_q   <= mul_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            pend_q      <= pend_d;
            pend_tgt_q  <= pend_tgt_d;
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (fetch_stall)  perf_stall_q <= perf_stall_q + 32'd1;
            if (decode_flush) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_cycles = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed vector table plus randomized traffic
// against a cycle-level reference model.
module tb_hazard_controller;
  import pipeline_pkg::*;

  localparam int L = 4;
  localparam int F = 2;

  typedef logic [38:0] out_t;  // {fs, je, ds, df, es, eb, mb, jump_address}

  typedef struct packed {
    logic        rst;
    logic        busy;
    logic        br;
    logic [31:0] tgt;
    logic        mstart;
    logic        ld;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    out_t       out;
    HazardState st;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_is_load, ex_muldiv_start, ex_branch_taken, mem_busy;
  logic [31:0] ex_branch_target;
  logic        fetch_stall, jump_enable, decode_stall, decode_flush;
  logic        execute_stall, execute_bubble, memory_bubble;
  logic [31:0] jump_address;
  HazardState  dbg_state;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] perf_stall_cycles, perf_flush_cycles;
  logic [31:0] m_perf_s, m_perf_f;
`endif

  int checks = 0;
  int errors = 0;
  logic [38:0] exp_q[$];
  vec_t tab[$];

  // model state: busy cycles left for a mul/div, flush slots left, pending redirect
  int          m_mul, m_fl;
  bit          m_pend;
  logic [31:0] m_tgt;

  hazard_controller #(.MULDIV_LATENCY(L), .FLUSH_CYCLES(F)) dut (
    .clk              (clk),
    .reset            (reset),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_uses_rs1      (id_uses_rs1),
    .id_uses_rs2      (id_uses_rs2),
    .ex_is_load       (ex_is_load),
    .ex_rd            (ex_rd),
    .ex_muldiv_start  (ex_muldiv_start),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .mem_busy         (mem_busy),
    .fetch_stall      (fetch_stall),
    .jump_enable      (jump_enable),
    .jump_address     (jump_address),
    .decode_stall     (decode_stall),
    .decode_flush     (decode_flush),
    .execute_stall    (execute_stall),
    .execute_bubble   (execute_bubble),
    .memory_bubble    (memory_bubble),
`ifdef HAZARD_PERF_COUNTERS_EN
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_cycles(perf_flush_cycles),
`endif
    .dbg_state        (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  function automatic out_t mk(bit fs, bit je, bit ds, bit df, bit es, bit eb, bit mb, logic [31:0] ja);
    return {fs, je, ds, df, es, eb, mb, ja};
  endfunction

  function automatic in_t mk_in(bit rst, bit busy, bit br, logic [31:0] tgt, bit mstart,
                                bit ld, logic [4:0] rd, logic [4:0] rs1, bit u1, logic [4:0] rs2, bit u2);
    in_t v;
    v.rst = rst; v.busy = busy; v.br = br; v.tgt = tgt; v.mstart = mstart;
    v.ld = ld; v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    return v;
  endfunction

  function automatic bit load_use_dep(in_t v);
    if (!v.ld || v.rd == 5'd0) return 1'b0;
    return (v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd);
  endfunction

  // reference model: mem_busy freezes everything; otherwise redirect, then
  // remaining flush slots, remaining mul/div cycles, new mul/div, load-use
  task automatic model_step(input in_t v, output out_t o, output HazardState st);
    o = '0;
    if (v.rst) begin
      m_mul = 0; m_fl = 0; m_pend = 0; m_tgt = '0;
`ifdef HAZARD_PERF_COUNTERS_EN
      m_perf_s = '0; m_perf_f = '0;
`endif
      st = RUN;
      return;
    end
    if (v.busy) begin
      o = mk(1, 0, 1, 0, 1, 0, 0, 0);
      if (v.br) begin m_pend = 1; m_tgt = v.tgt; end
    end else if (m_pend || v.br) begin
      o = mk(0, 1, 0, 1, 0, 1, 0, m_pend ? m_tgt : v.tgt);
      m_pend = 0; m_mul = 0; m_fl = F - 1;
    end else if (m_fl > 0) begin
      o = mk(0, 0, 0, 1, 0, 0, 0, 0);
      m_fl--;
    end else if (m_mul > 0) begin
      if (m_mul > 1) o = mk(1, 0, 1, 0, 1, 0, 1, 0);
      m_mul--;
    end else if (v.mstart) begin
      o = mk(1, 0, 1, 0, 1, 0, 1, 0);
      m_mul = L - 1;
    end else if (load_use_dep(v)) begin
      o = mk(1, 0, 1, 0, 0, 1, 0, 0);
    end
`ifdef HAZARD_PERF_COUNTERS_EN
    if (o[38]) m_perf_s++;
    if (o[35]) m_perf_f++;
`endif
    st = v.busy ? MEM_WAIT : (m_fl > 0) ? FLUSH : (m_mul > 0) ? MULDIV : RUN;
  endtask

  // driver
  task automatic set_inputs(input in_t v);
    reset = v.rst; mem_busy = v.busy; ex_branch_taken = v.br; ex_branch_target = v.tgt;
    ex_muldiv_start = v.mstart; ex_is_load = v.ld; ex_rd = v.rd;
    id_rs1 = v.rs1; id_uses_rs1 = v.u1; id_rs2 = v.rs2; id_uses_rs2 = v.u2;
  endtask

  // one cycle: drive after posedge, check outputs at negedge, check state after next posedge
  task automatic step(input string name, input in_t v, input bit use_tab, input out_t t_out, input HazardState t_st);
    out_t m_out, act, exp;
    HazardState m_st, exp_st;
    set_inputs(v);
    model_step(v, m_out, m_st);
    exp_q.push_back(use_tab ? t_out : m_out);
    exp_st = use_tab ? t_st : m_st;
    @(negedge clk);
    act = {fetch_stall, jump_enable, decode_stall, decode_flush, execute_stall,
           execute_bubble, memory_bubble, jump_address};
    exp = exp_q.pop_front();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s outputs got=%h want=%h", name, act, exp);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dbg_state !== exp_st) begin
      errors++;
      $display("FAIL %s state got=%0d want=%0d", name, dbg_state, exp_st);
    end
`ifdef HAZARD_PERF_COUNTERS_EN
    checks++;
    if (perf_stall_cycles !== m_perf_s || perf_flush_cycles !== m_perf_f) begin
      errors++;
      $display("FAIL %s perf got=%0d/%0d want=%0d/%0d", name, perf_stall_cycles,
               perf_flush_cycles, m_perf_s, m_perf_f);
    end
`endif
  endtask

  task automatic add(input string name, input in_t v, input out_t o, input HazardState st);
    vec_t e;
    e.name = name; e.in = v; e.out = o; e.st = st;
    tab.push_back(e);
  endtask

  initial begin
    in_t  idle, v;
    out_t z, busy_o, lu_o, mul_o, fl_o;
    out_t dummy_o;

    idle   = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    z      = '0;
    busy_o = mk(1, 0, 1, 0, 1, 0, 0, 0);
    lu_o   = mk(1, 0, 1, 0, 0, 1, 0, 0);
    mul_o  = mk(1, 0, 1, 0, 1, 0, 1, 0);
    fl_o   = mk(0, 0, 0, 1, 0, 0, 0, 0);
    m_mul = 0; m_fl = 0; m_pend = 0; m_tgt = '0;
`ifdef HAZARD_PERF_COUNTERS_EN
    m_perf_s = '0; m_perf_f = '0;
`endif

    add("reset_all_hi", mk_in(1, 1, 1, 32'h55, 1, 1, 5, 5, 1, 5, 1), z, RUN);
    add("reset_idle",   mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), z, RUN);
    add("lu_rs1",       mk_in(0, 0, 0, 0, 0, 1, 5, 5, 1, 1, 1), lu_o, RUN);
    add("lu_after",     mk_in(0, 0, 0, 0, 0, 0, 0, 5, 1, 1, 1), z, RUN);
    add("lu_rs2",       mk_in(0, 0, 0, 0, 0, 1, 7, 2, 1, 7, 1), lu_o, RUN);
    add("lu_unused",    mk_in(0, 0, 0, 0, 0, 1, 7, 7, 0, 7, 0), z, RUN);
    add("lu_x0",        mk_in(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1), z, RUN);
    add("lu_noload",    mk_in(0, 0, 0, 0, 0, 0, 5, 5, 1, 0, 0), z, RUN);
    for (int i = 0; i < 3; i++)
      add("mul_busy",   mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), mul_o, MULDIV);
    add("mul_release",  mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), z, RUN);
    add("mul_done",     idle, z, RUN);
    add("br_jump",      mk_in(0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0), mk(0, 1, 0, 1, 0, 1, 0, 32'h100), FLUSH);
    add("br_flush",     idle, fl_o, RUN);
    add("br_done",      idle, z, RUN);
    add("mw_busy1",     mk_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), busy_o, MEM_WAIT);
    add("mw_busy2_br",  mk_in(0, 1, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0), busy_o, MEM_WAIT);
    add("mw_busy3",     mk_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), busy_o, MEM_WAIT);
    add("mw_jump",      idle, mk(0, 1, 0, 1, 0, 1, 0, 32'h200), FLUSH);
    add("mw_flush",     idle, fl_o, RUN);
    add("all_redirect", mk_in(0, 0, 1, 32'h300, 1, 1, 5, 5, 1, 0, 0), mk(0, 1, 0, 1, 0, 1, 0, 32'h300), FLUSH);
    add("all_flush",    idle, fl_o, RUN);
    add("rl_first",     mk_in(0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0), mk(0, 1, 0, 1, 0, 1, 0, 32'h100), FLUSH);
    add("rl_reload",    mk_in(0, 0, 1, 32'h180, 0, 0, 0, 0, 0, 0, 0), mk(0, 1, 0, 1, 0, 1, 0, 32'h180), FLUSH);
    add("rl_flush",     idle, fl_o, RUN);
    add("mb_start",     mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), mul_o, MULDIV);
    add("mb_busy1",     mk_in(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), busy_o, MEM_WAIT);
    add("mb_busy2",     mk_in(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0), busy_o, MEM_WAIT);
    add("mb_resume1",   mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), mul_o, MULDIV);
    add("mb_resume2",   mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), mul_o, MULDIV);
    add("mb_release",   mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), z, RUN);
    add("mb_done",      idle, z, RUN);
    add("rs_start",     mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), mul_o, MULDIV);
    add("rs_cnt2",      mk_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), mul_o, MULDIV);
    add("rs_reset",     mk_in(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), z, RUN);
    add("rs_after",     idle, z, RUN);
    add("pj_busy_br",   mk_in(0, 1, 1, 32'h400, 0, 0, 0, 0, 0, 0, 0), busy_o, MEM_WAIT);
    add("pj_reset",     mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), z, RUN);
    add("pj_dropped",   idle, z, RUN);
    add("fb_jump",      mk_in(0, 0, 1, 32'h500, 0, 0, 0, 0, 0, 0, 0), mk(0, 1, 0, 1, 0, 1, 0, 32'h500), FLUSH);
    add("fb_busy",      mk_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), busy_o, MEM_WAIT);
    add("fb_resume",    idle, fl_o, RUN);

    // reset block
    set_inputs(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;

    for (int i = 0; i < tab.size(); i++)
      step(tab[i].name, tab[i].in, 1'b1, tab[i].out, tab[i].st);

    dummy_o = '0;
    for (int i = 0; i < 3000; i++) begin
      v.rst    = ($urandom_range(0, 99) == 0);
      v.busy   = ($urandom_range(0, 99) < 15);
      v.br     = ($urandom_range(0, 99) < 10);
      v.tgt    = $urandom;
      v.mstart = ($urandom_range(0, 99) < 10);
      v.ld     = ($urandom_range(0, 99) < 40);
      v.rd     = 5'($urandom_range(0, 3));
      v.rs1    = 5'($urandom_range(0, 3));
      v.u1     = 1'($urandom_range(0, 1));
      v.rs2    = 5'($urandom_range(0, 3));
      v.u2     = 1'($urandom_range(0, 1));
      step("random", v, 1'b0, dummy_o, RUN);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central stall/flush/redirect sequencer for the 5-stage RV32I pipeline.
- Drives the fetch stage's stall and jump inputs, plus stall/flush/bubble controls for decode, execute and memory.
- Resolves load-use hazards, data-memory wait states, multi-cycle mul/div occupancy and taken-branch redirects through one prioritised state machine.

Parameters:
- MULDIV_LATENCY, 4: execute-stage busy cycles per mul/div op (range 2..15).
- FLUSH_CYCLES, 2: wrong-path slots squashed after a redirect (range 1..3).

Ports:
- clk  in  1  pipeline clock (Clock).
- reset  in  1  synchronous, active-high reset.
- id_rs1  in  5  decode-stage source register 1 index.
- id_rs2  in  5  decode-stage source register 2 index.
- id_uses_rs1  in  1  decode instruction reads rs1.
- id_uses_rs2  in  1  decode instruction reads rs2.
- ex_is_load  in  1  execute-stage instruction is a load.
- ex_rd  in  5  execute-stage destination index.
- ex_muldiv_start  in  1  execute-stage mul/div issued this cycle.
- ex_branch_taken  in  1  execute resolved a taken branch or jump.
- ex_branch_target  in  32  redirect target (Addr).
- mem_busy  in  1  data memory not ready; whole pipe must hold.
- fetch_stall  out  1  to fetch stage stall.
- jump_enable  out  1  to fetch stage jump_enable.
- jump_address  out  32  to fetch stage jump_address.
- decode_stall  out  1  hold decode register.
- decode_flush  out  1  replace decode register with NOP.
- execute_stall  out  1  hold execute register.
- execute_bubble  out  1  inject NOP into execute.
- memory_bubble  out  1  inject NOP into memory.

Behaviour:
- Clocking and reset:
  - Single clock; synchronous, active-high reset.
  - On reset: state=RUN, counters=0, pending_jump=0, pending_target=0; every output 0.
  - Reset mid-WAIT/MULDIV/FLUSH aborts to RUN next edge and drops any pending jump.
- States: RUN, MEM_WAIT, MULDIV, FLUSH. Outputs are combinational from state plus inputs.
- Priority within a cycle: mem_busy > redirect > muldiv > load-use.
- mem_busy=1 in any state:
  - Asserts fetch_stall, decode_stall and execute_stall; memory holds itself.
  - jump_enable=0. State -> MEM_WAIT; counters frozen.
  - If ex_branch_taken arrives while busy, latch pending_jump=1 and pending_target.
- MEM_WAIT with mem_busy=0:
  - If pending_jump is set, issue redirect with pending_target this cycle and clear pending_jump.
  - Otherwise resume the saved state (MULDIV or FLUSH with its counter intact), else RUN.
- Redirect (ex_branch_taken=1, mem_busy=0):
  - Same cycle: jump_enable=1, jump_address=ex_branch_target, decode_flush=1, execute_bubble=1.
  - flush_cnt=FLUSH_CYCLES-1 -> FLUSH if nonzero, else RUN.
  - A redirect also cancels a concurrent muldiv start and a pending load-use.
- FLUSH: decode_flush=1 each cycle; flush_cnt decrements; 0 -> RUN. A new redirect in FLUSH reloads the counter.
- MULDIV:
  - Entered on ex_muldiv_start in RUN; mul_cnt=MULDIV_LATENCY-1.
  - While mul_cnt>0: fetch_stall, decode_stall and execute_stall asserted; memory_bubble=1.
  - mul_cnt=0: release all stalls, -> RUN. ex_muldiv_start is ignored while in MULDIV.
- Load-use (RUN only):
  - Condition: ex_is_load, ex_rd!=0, and (id_uses_rs1 with id_rs1==ex_rd, or id_uses_rs2 with id_rs2==ex_rd).
  - Asserts fetch_stall, decode_stall and execute_bubble for exactly 1 cycle; no state change.
  - The bubble clears ex_is_load, so the condition self-terminates.
- Register x0 never triggers a hazard.
- Counters are 4-bit unsigned and never wrap; decrement stops at 0.

Optional Feature:
- Macro HAZARD_PERF_COUNTERS_EN.
- Defined: adds outputs perf_stall_cycles (32) and perf_flush_cycles (32).
  - perf_stall_cycles increments on each cycle with fetch_stall=1.
  - perf_flush_cycles increments on each cycle with decode_flush=1.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- pipeline_pkg holds:
  - typedef RegIdx (5-bit).
  - enum HazardState {RUN, MEM_WAIT, MULDIV, FLUSH}.
  - Existing Addr/Bool/Clock types.
  - Constant REG_ZERO=0.
- Sub-module load_use_detect: pure comparator taking the id/ex fields, producing one Bool. It is reused by the future forwarding unit.

Test Plan:
- Load x5, then add x6,x5,x1 in decode -> 1 cycle of fetch_stall/decode_stall/execute_bubble; no stall on the next cycle. Same sequence with rd=x0 -> no stall.
- ex_muldiv_start at cycle 10, MULDIV_LATENCY=4 -> stalls high cycles 10-12, low at 13; memory_bubble high 10-12.
- ex_branch_taken, target 0x0000_0100 -> jump_enable=1 with that address the same cycle; decode_flush high 2 cycles (FLUSH_CYCLES=2); fetch next address 0x104.
- mem_busy high 3 cycles; ex_branch_taken (0x200) arrives on busy cycle 2 -> no jump while busy; jump_enable=1 with 0x200 on the first cycle after mem_busy falls.
- Same cycle ex_branch_taken, ex_muldiv_start and load-use -> redirect only; state FLUSH, never MULDIV.
- reset asserted in MULDIV with mul_cnt=2 -> all outputs 0 the next cycle; state RUN. With HAZARD_PERF_COUNTERS_EN, counters read 0.
